// File: rtl/ttl_pkg.sv
// Shared TTL model library definitions: width limit and the counter step function.
// The step function works on the widest counter so any instance width can reuse it.
package ttl_pkg;

  localparam int TTL_MAX_WIDTH = 32;

  typedef logic [TTL_MAX_WIDTH-1:0] ttl_word_t;
  typedef logic [TTL_MAX_WIDTH:0]   ttl_mod_t;

  // Out-of-range values recover in one step when counting up and
  // walk down through plain decrements when counting down.
  function automatic ttl_word_t ttl_next_count(
    input ttl_word_t cnt,
    input logic      up,
    input ttl_mod_t  modulus,
    input int        width
  );
    ttl_mod_t last;
    ttl_mod_t mask;
    ttl_mod_t c;
    ttl_mod_t n;
    last = modulus - ttl_mod_t'(1);
    mask = (ttl_mod_t'(1) << width) - ttl_mod_t'(1);
    c    = {1'b0, cnt};
    if (up) begin
      n = (c >= last) ? '0 : c + ttl_mod_t'(1);
    end else begin
      n = (c == '0) ? last : c - ttl_mod_t'(1);
    end
    return TTL_MAX_WIDTH'(n & mask);
  endfunction

endpackage

// File: rtl/ttl_tristate_bus.sv
// 74244-style bus driver: Y follows A while G_n is low, otherwise floats.
module ttl_tristate_bus #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic             G_n,
  output logic [WIDTH-1:0] Y
);

  assign Y = G_n ? {WIDTH{1'bz}} : A;

endmodule

// File: rtl/ttl_counter_n.sv
// Parametrised 74161/74163/74160/74191-style counter with load, ENP/ENT cascade
// enables, combinational ripple carry and tri-state outputs.
module ttl_counter_n
  import ttl_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD_n,
  input  logic [WIDTH-1:0] D,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  input  logic             OE_n,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  if (WIDTH < 1 || WIDTH > TTL_MAX_WIDTH) begin : g_bad_width
    $error("ttl_counter_n: WIDTH must be 1..32");
  end
  if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("ttl_counter_n: MODULUS must be 2..2**WIDTH");
  end

  localparam ttl_mod_t         MOD_W = ttl_mod_t'(MODULUS);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] cnt;
  logic             tc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (!LOAD_n) begin
      cnt <= D;
    end else if (ENP && ENT) begin
      cnt <= WIDTH'(ttl_next_count(TTL_MAX_WIDTH'(cnt), UP, MOD_W, WIDTH));
    end
  end

  // Terminal count depends on direction so RCO tracks UP without a clock edge.
  assign tc  = UP ? (cnt == LAST) : (cnt == '0);
  assign RCO = ENT & tc;

  ttl_tristate_bus #(.WIDTH(WIDTH)) u_out (
    .A  (cnt),
    .G_n(OE_n),
    .Y  (Q)
  );

endmodule

// File: tb/tb_ttl_counter_n.sv
// Directed bench: binary and decade counters, load/tri-state behaviour, async reset, 8-bit cascade.
module tb_ttl_counter_n;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Binary modulus-16 counter
  logic       rst, load_n, enp, ent, up, oe_n;
  logic [3:0] d, q;
  logic       rco;

  ttl_counter_n #(.WIDTH(4), .MODULUS(16)) u_bin (
    .CLK(CLK), .RST(rst), .LOAD_n(load_n), .D(d), .ENP(enp), .ENT(ent),
    .UP(up), .OE_n(oe_n), .Q(q), .RCO(rco)
  );

  // Decade counter
  logic       d_load_n, d_enp, d_up;
  logic [3:0] d_d, d_q;
  logic       d_rco;

  ttl_counter_n #(.WIDTH(4), .MODULUS(10)) u_dec (
    .CLK(CLK), .RST(rst), .LOAD_n(d_load_n), .D(d_d), .ENP(d_enp), .ENT(1'b1),
    .UP(d_up), .OE_n(1'b0), .Q(d_q), .RCO(d_rco)
  );

  // Two-stage cascade
  logic       c_rst, c_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_rco, hi_rco;

  ttl_counter_n #(.WIDTH(4)) u_lo (
    .CLK(CLK), .RST(c_rst), .LOAD_n(1'b1), .D(4'h0), .ENP(c_en), .ENT(1'b1),
    .UP(1'b1), .OE_n(1'b0), .Q(lo_q), .RCO(lo_rco)
  );
  ttl_counter_n #(.WIDTH(4)) u_hi (
    .CLK(CLK), .RST(c_rst), .LOAD_n(1'b1), .D(4'h0), .ENP(c_en), .ENT(lo_rco),
    .UP(1'b1), .OE_n(1'b0), .Q(hi_q), .RCO(hi_rco)
  );

  logic [3:0] zz;
  int         v;

  initial begin
    zz = 'z;
    rst = 1'b1; load_n = 1'b1; d = 4'h0; enp = 1'b0; ent = 1'b1; up = 1'b1; oe_n = 1'b0;
    d_load_n = 1'b1; d_d = 4'h0; d_enp = 1'b0; d_up = 1'b1;
    c_rst = 1'b1; c_en = 1'b0;

    // Reset without any clock edge
    #2;
    chk("rst_q_noclk", 32'(q), 32'h0);
    chk("rst_rco_up", 32'(rco), 32'h0);
    up = 1'b0;
    #1;
    chk("rst_rco_down", 32'(rco), 32'h1);
    up = 1'b1;
    #1;
    chk("rst_rco_up_again", 32'(rco), 32'h0);

    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("hold_q", 32'(q), 32'h0);
    chk("hold_rco", 32'(rco), 32'h0);

    // Binary up wrap
    enp = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("bin_q", 32'(q), 32'(i % 16));
      chk("bin_rco", 32'(rco), 32'((i % 16) == 15));
    end

    // Load wins over count on the same edge
    load_n = 1'b0; d = 4'hA; enp = 1'b1; ent = 1'b1;
    tick();
    chk("load_prio", 32'(q), 32'hA);
    load_n = 1'b1;

    // Outputs floated while counting continues
    oe_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("oe_z", 32'(q), 32'(zz));
      chk("oe_rco", 32'(rco), 32'h0);
    end
    oe_n = 1'b0;
    #1;
    chk("oe_back", 32'(q), 32'hD);

    // 13 -> 14, 15, 0 .. 7
    for (int i = 0; i < 10; i++) tick();
    chk("pre_arst", 32'(q), 32'h7);
    #2 rst = 1'b1;
    #1 chk("arst_q", 32'(q), 32'h0);
    rst = 1'b0;
    tick();
    chk("arst_release", 32'(q), 32'h1);

    // Reset held across an edge discards a pending load
    load_n = 1'b0; d = 4'h9;
    rst = 1'b1;
    tick();
    chk("arst_load", 32'(q), 32'h0);
    rst = 1'b0; load_n = 1'b1; enp = 1'b0;

    // Decade counter (reset cleared it above)
    tick();
    chk("dec_start", 32'(d_q), 32'h0);
    d_enp = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("dec_q", 32'(d_q), 32'(i % 10));
      chk("dec_rco", 32'(d_rco), 32'((i % 10) == 9));
    end
    d_enp = 1'b0;
    d_load_n = 1'b0; d_d = 4'd13;
    tick();
    chk("dec_ld13", 32'(d_q), 32'd13);
    d_load_n = 1'b1; d_enp = 1'b1;
    tick();
    chk("dec_up_recover", 32'(d_q), 32'd0);
    d_enp = 1'b0; d_load_n = 1'b0;
    tick();
    d_load_n = 1'b1; d_enp = 1'b1; d_up = 1'b0;
    tick();
    chk("dec_down_13", 32'(d_q), 32'd12);
    d_enp = 1'b0; d_load_n = 1'b0; d_d = 4'd0;
    tick();
    chk("dec_rco_down0", 32'(d_rco), 32'h1);
    d_load_n = 1'b1; d_enp = 1'b1;
    tick();
    chk("dec_down_wrap", 32'(d_q), 32'd9);
    chk("dec_rco_down9", 32'(d_rco), 32'h0);
    d_enp = 1'b0;

    // Cascade: 300 clocks
    c_rst = 1'b0;
    c_en  = 1'b1;
    v = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      v = (v + 1) % 256;
      chk("cascade_step", {24'h0, hi_q, lo_q}, 32'(v));
    end
    chk("cascade_300", {24'h0, hi_q, lo_q}, 32'd44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
